tx_chip_encoder: RTL and testbench

Transmit-side counterpart of the CDR bit-decision stage. Accepts payload bytes over a valid/ready handshake, splits each into two 4-bit symbols (low nibble first) and maps each symbol to its IEEE 802.15.4 32-chip PN sequence. It then serializes the chips as a phase stream, holding each chip for `i_nb_P` sample strobes. The stream feeds the O-QPSK/MSK modulator path, and a receive-side decision stage recovers each chip as `~phase`.

---
 rtl/zigbee_pkg.sv | 39 +++
 rtl/tx_chip_encoder_chip_timer.sv | 26 ++
 rtl/tx_chip_encoder.sv | 123 ++++++++++++
 tb/tb_tx_chip_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pkg.sv
// Shared constants for the 802.15.4 O-QPSK chip encoder.
// Chip words are stored c0-first: c0 is the MSB.
package zigbee_pkg;

  localparam int CHIPS_PER_SYM = 32;
  localparam logic [5:0] NBP_MIN = 6'd2;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  localparam logic [31:0] CHIP_TABLE [16] = '{
    32'hD9C3522E, 32'hED9C3522,
    32'h2ED9C352, 32'h22ED9C35,
    32'h522ED9C3, 32'h3522ED9C,
    32'hC3522ED9, 32'h9C3522ED,
    32'h8C96077B, 32'hB8C96077,
    32'h7B8C9607, 32'h77B8C960,
    32'h077B8C96, 32'h6077B8C9,
    32'h96077B8C, 32'hC96077B8
  };

  function automatic logic chip_bit(
    input logic [3:0] sym,
    input logic [4:0] idx
  );
    logic [31:0] w;
    w = CHIP_TABLE[sym];
    return w[5'(CHIPS_PER_SYM - 1) - idx];
  endfunction

  function automatic logic [5:0] nbp_sat(
    input logic [5:0] n
  );
    return (n < NBP_MIN) ? NBP_MIN : n;
  endfunction

endpackage

// File: rtl/tx_chip_encoder_chip_timer.sv
// Samples-per-chip counter with terminal-count flag.
// Cleared on frame start, wraps on every chip boundary.
module chip_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [5:0] i_nbp,
  output logic       o_chip_end
);

  logic [5:0] smp_cnt;

  assign o_chip_end = (smp_cnt == i_nbp - 6'd1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      smp_cnt <= '0;
    end else if (i_load) begin
      smp_cnt <= '0;
    end else if (i_en) begin
      smp_cnt <= o_chip_end ? '0 : smp_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/tx_chip_encoder.sv
// Byte -> 2 symbols -> 32-chip PN sequences, serialized as a
// phase stream holding each chip for nbp_q sample strobes.
module tx_chip_encoder
  import zigbee_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en_ech,
  input  logic [5:0] i_nb_P,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_phase,
  output logic       o_flag,
  output logic       o_busy,
  output logic       o_underrun
);

  tx_state_t  state;
  logic       nib_sel;
  logic [4:0] chip_idx;
  logic [5:0] nbp_q;
  logic [7:0] byte_q;
  logic       last_q;

  logic       chip_end;
  logic       adv;
  logic       sym_end;
  logic       byte_end;
  logic       accept;
  logic       start;
  logic [3:0] cur_sym;
  logic [4:0] nxt_idx;

  assign adv      = (state == SEND) && i_en_ech && chip_end;
  assign sym_end  = (chip_idx == 5'd31);
  assign byte_end = adv && sym_end && nib_sel;
  assign o_ready  = (state == IDLE) || (byte_end && !last_q);
  assign accept   = i_valid && o_ready;
  assign start    = (state == IDLE) && i_valid;
  assign cur_sym  = nib_sel ? byte_q[7:4] : byte_q[3:0];
  assign nxt_idx  = chip_idx + 5'd1;

  chip_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (start),
    .i_en       ((state == SEND) && i_en_ech),
    .i_nbp      (nbp_q),
    .o_chip_end (chip_end)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      nib_sel    <= 1'b0;
      chip_idx   <= '0;
      nbp_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      o_phase    <= 1'b0;
      o_flag     <= 1'b0;
      o_busy     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_flag     <= 1'b0;
      o_underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          o_phase <= 1'b0;
          o_busy  <= 1'b0;
          if (i_valid) begin
            byte_q   <= i_data;
            last_q   <= i_last;
            nbp_q    <= nbp_sat(i_nb_P);
            nib_sel  <= 1'b0;
            chip_idx <= '0;
            o_phase  <= ~chip_bit(i_data[3:0], 5'd0);
            o_flag   <= 1'b1;
            o_busy   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          unique case (1'b1)
            adv && !sym_end: begin
              chip_idx <= nxt_idx;
              o_phase  <= ~chip_bit(cur_sym, nxt_idx);
              o_flag   <= 1'b1;
            end
            adv && sym_end && !nib_sel: begin
              nib_sel  <= 1'b1;
              chip_idx <= '0;
              o_phase  <= ~chip_bit(byte_q[7:4], 5'd0);
              o_flag   <= 1'b1;
            end
            byte_end && accept: begin
              // seamless continuation keeps the frame's nbp_q
              byte_q   <= i_data;
              last_q   <= i_last;
              nib_sel  <= 1'b0;
              chip_idx <= '0;
              o_phase  <= ~chip_bit(i_data[3:0], 5'd0);
              o_flag   <= 1'b1;
            end
            byte_end && !accept: begin
              state      <= IDLE;
              nib_sel    <= 1'b0;
              chip_idx   <= '0;
              o_phase    <= 1'b0;
              o_busy     <= 1'b0;
              o_underrun <= !last_q;
            end
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_chip_encoder.sv
// Directed bench for tx_chip_encoder: chip order, timing,
// back-to-back, underrun, nbp saturation, strobe gaps, reset.
module tb_tx_chip_encoder;

  logic       clk;
  logic       i_rst;
  logic       i_en_ech;
  logic [5:0] i_nb_P;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_last;
  logic       o_ready;
  logic       o_phase;
  logic       o_flag;
  logic       o_busy;
  logic       o_underrun;

  int tests = 0;
  int fails = 0;
  int flag_total;

  localparam logic [31:0] TBL [16] = '{
    32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
    32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
    32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
    32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
  };

  tx_chip_encoder dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_en_ech   (i_en_ech),
    .i_nb_P     (i_nb_P),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_phase    (o_phase),
    .o_flag     (o_flag),
    .o_busy     (o_busy),
    .o_underrun (o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ph(input logic [7:0] b, input int ci);
    logic [31:0] w;
    w = (ci < 32) ? TBL[b[3:0]] : TBL[b[7:4]];
    return ~w[31 - (ci % 32)];
  endfunction

  task automatic start(input logic [7:0] b, input logic l,
                       input logic [5:0] nbp);
    @(negedge clk);
    i_data   = b;
    i_last   = l;
    i_nb_P   = nbp;
    i_valid  = 1'b1;
    i_en_ech = 1'b1;
    #1 chk(32'(o_ready), 32'd1, "idle_ready");
  endtask

  // Walks one byte: per-cycle checks on phase/flag/busy/ready.
  task automatic run_byte(input logic [7:0] b, input logic lastb,
                          input int nbp, input int period,
                          input logic nxt, input logic [7:0] nb,
                          input logic nlast, input string tag);
    int errs;
    int flags;
    logic is_end;
    errs  = 0;
    flags = 0;
    for (int ci = 0; ci < 64; ci++) begin
      for (int s = 0; s < nbp; s++) begin
        for (int g = 0; g < period; g++) begin
          @(negedge clk);
          if (o_phase !== exp_ph(b, ci)) errs++;
          if (o_flag !== (s == 0 && g == 0)) errs++;
          if (o_busy !== 1'b1) errs++;
          if (o_flag === 1'b1) flags++;
          i_nb_P   = 6'($urandom);
          i_en_ech = (g == period - 1);
          is_end   = (ci == 63) && (s == nbp - 1) && i_en_ech;
          i_valid  = is_end && nxt;
          i_data   = nb;
          i_last   = nlast;
          #1;
          if (o_ready !== (is_end && !lastb)) errs++;
        end
      end
    end
    flag_total += flags;
    chk(32'(errs), 32'd0, {tag, "_stream_errs"});
    chk(32'(flags), 32'd64, {tag, "_flags"});
  endtask

  task automatic check_idle(input logic exp_under, input string tag);
    @(negedge clk);
    chk(32'(o_busy), 32'd0, {tag, "_busy"});
    chk(32'(o_phase), 32'd0, {tag, "_phase"});
    chk(32'(o_ready), 32'd1, {tag, "_ready"});
    chk(32'(o_underrun), 32'(exp_under), {tag, "_underrun"});
    @(negedge clk);
    chk(32'(o_underrun), 32'd0, {tag, "_underrun_clr"});
    chk(32'(o_flag), 32'd0, {tag, "_flag"});
  endtask

  initial begin
    i_rst    = 1'b0;
    i_en_ech = 1'b0;
    i_nb_P   = 6'd4;
    i_data   = 8'h00;
    i_valid  = 1'b0;
    i_last   = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(o_phase), 32'd0, "rst_phase");
    chk(32'(o_flag), 32'd0, "rst_flag");
    chk(32'(o_busy), 32'd0, "rst_busy");
    chk(32'(o_underrun), 32'd0, "rst_underrun");
    chk(32'(o_ready), 32'd1, "rst_ready");
    i_rst = 1'b1;

    // single byte, both nibbles symbol 0
    start(8'h00, 1'b1, 6'd4);
    run_byte(8'h00, 1'b1, 4, 1, 1'b0, 8'h00, 1'b0, "b00");
    check_idle(1'b0, "b00_end");

    // low nibble 0, high nibble 1
    start(8'h10, 1'b1, 6'd4);
    run_byte(8'h10, 1'b1, 4, 1, 1'b0, 8'h00, 1'b0, "b10");
    check_idle(1'b0, "b10_end");

    // back-to-back, second byte offered at the end strobe
    flag_total = 0;
    start(8'hA5, 1'b0, 6'd4);
    run_byte(8'hA5, 1'b0, 4, 1, 1'b1, 8'h3C, 1'b1, "b2b_a");
    run_byte(8'h3C, 1'b1, 4, 1, 1'b0, 8'h00, 1'b0, "b2b_b");
    chk(32'(flag_total), 32'd128, "b2b_flag_total");
    check_idle(1'b0, "b2b_end");

    // frame with no last byte: underrun
    start(8'h5A, 1'b0, 6'd3);
    run_byte(8'h5A, 1'b0, 3, 1, 1'b0, 8'h00, 1'b0, "und");
    check_idle(1'b1, "und_end");

    // nbp 0 saturates to 2
    start(8'hF0, 1'b1, 6'd0);
    run_byte(8'hF0, 1'b1, 2, 1, 1'b0, 8'h00, 1'b0, "nbp0");
    check_idle(1'b0, "nbp0_end");

    // strobe 1 in 3 cycles
    start(8'h97, 1'b1, 6'd4);
    run_byte(8'h97, 1'b1, 4, 3, 1'b0, 8'h00, 1'b0, "slow");
    check_idle(1'b0, "slow_end");

    // async reset at chip 10
    start(8'h00, 1'b1, 6'd4);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (39) @(negedge clk);
    chk(32'(o_busy), 32'd1, "pre_rst_busy");
    #2 i_rst = 1'b0;
    #1;
    chk(32'(o_busy), 32'd0, "mid_rst_busy");
    chk(32'(o_phase), 32'd0, "mid_rst_phase");
    chk(32'(o_flag), 32'd0, "mid_rst_flag");
    chk(32'(o_ready), 32'd1, "mid_rst_ready");
    @(negedge clk);
    chk(32'(o_underrun), 32'd0, "mid_rst_underrun");
    i_rst = 1'b1;
    start(8'h21, 1'b1, 6'd4);
    run_byte(8'h21, 1'b1, 4, 1, 1'b0, 8'h00, 1'b0, "post_rst");
    check_idle(1'b0, "post_rst_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
